pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 5 +
 rtl/pipe_payload_reg.sv | 16 +
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline stage encoding and constants
package pipe_stage_reg_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} stage_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: loadable payload register with synchronous clear to a preset value
module pipe_payload_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  // clear wins over load; otherwise hold
  always_ff @(posedge clk) data_q <= clr_i ? RST_VAL : ld_i ? d_i : data_q;
  assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: skid-buffered pipeline stage register with redirect, kill and stall counter
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h0000_4180)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [15:0]        stall_cnt
);
  localparam int PW = PC_W + INSTR_W + EXC_W + 1;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);
  stage_state_e state_q, state_d;
  logic in_ready_q, in_xfer, out_xfer, ld_main, ld_skid;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic [15:0] stall_q;
  assign in_pl = {in_pc, in_instr, in_exc, in_bd};
  assign {out_pc, out_instr, out_exc, out_bd} = main_q;
  assign out_valid = state_q != EMPTY;
  assign in_ready = in_ready_q;
  assign stall_cnt = stall_q;
  assign in_xfer = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;
  // next occupancy and main/skid loads; redirect and kill override any handshake
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    if (req) begin
      state_d = EMPTY;
      main_d = {HANDLER_PC, NOP, {(EXC_W + 1){1'b0}}};
      ld_main = 1'b1;
    end else if (flush) begin
      state_d = EMPTY;
      main_d = {out_pc, NOP, {(EXC_W + 1){1'b0}}};
      ld_main = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = ONE;
          main_d = in_pl;
          ld_main = 1'b1;
        end
        ONE: if (in_xfer && out_xfer) begin
          main_d = in_pl;
          ld_main = 1'b1;
        end else if (in_xfer) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
          main_d = {out_pc, NOP, out_exc, out_bd};
          ld_main = 1'b1;
        end
        FULL: if (out_xfer) begin
          state_d = ONE;
          main_d = skid_q;
          ld_main = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // occupancy, registered ready and saturating stall counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= state_d != FULL;
      stall_q <= (out_valid && !out_ready && !(&stall_q)) ? stall_q + 16'd1 : stall_q;
    end
  end
  pipe_payload_reg #(.W(PW), .RST_VAL({RESET_PC, {(PW - PC_W){1'b0}}})) u_main (
    .clk(clk), .clr_i(!reset_n), .ld_i(ld_main), .d_i(main_d), .q_o(main_q)
  );
  pipe_payload_reg #(.W(PW), .RST_VAL('0)) u_skid (
    .clk(clk), .clr_i(!reset_n), .ld_i(ld_skid), .d_i(in_pl), .q_o(skid_q)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_bd = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic [4:0] in_exc = '0;
  logic in_ready, out_valid, out_bd;
  logic [31:0] out_pc, out_instr;
  logic [4:0] out_exc;
  logic [15:0] stall_cnt;
  int tests_run = 0, tests_failed = 0;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic [4:0] exc; logic bd;} ent_t;
  ent_t mq[$];
  ent_t m_out = '0;
  logic m_rdy = 1'b1;
  logic [15:0] m_stall = '0;

  pipe_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_bd(out_bd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic inx, outx;
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
      m_out = '0;
      m_rdy = 1'b1;
      m_stall = '0;
    end else begin
      inx = in_valid && m_rdy;
      outx = mq.size() != 0 && out_ready;
      if (mq.size() != 0 && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (req) begin
        mq.delete();
        m_out = '{pc: 32'h0000_4180, instr: 32'h0, exc: 5'h0, bd: 1'b0};
      end else if (flush) begin
        mq.delete();
        m_out.instr = '0;
        m_out.exc = '0;
        m_out.bd = 1'b0;
      end else begin
        if (outx) void'(mq.pop_front());
        if (inx) mq.push_back('{pc: in_pc, instr: in_instr, exc: in_exc, bd: in_bd});
        if (mq.size() != 0) m_out = mq[0];
        else if (outx) m_out.instr = '0;
      end
      m_rdy = mq.size() < 2;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests_run++;
    if ({out_pc, out_instr, out_exc, out_bd} !== 70'h0) begin
      tests_failed++; $display("FAIL reset_payload got %h %h %h %b exp all zero", out_pc, out_instr, out_exc, out_bd);
    end
    tests_run++;
    if (stall_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_stall got %h exp 0", stall_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'hDEAD_0001; in_exc = 5'h0A; in_bd = 1'b1; out_ready = 1'b1;
    tests_run++;
    if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL latency_pre_pc got %h exp 0", out_pc); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_pc, out_instr, out_exc, out_bd} !== {1'b1, 32'h3000, 32'hDEAD_0001, 5'h0A, 1'b1}) begin
      tests_failed++; $display("FAIL latency_out got %b %h %h %h %b exp 1 3000 dead0001 0a 1", out_valid, out_pc, out_instr, out_exc, out_bd);
    end
    step();
    tests_run++;
    if ({out_valid, out_pc, out_instr, out_exc, out_bd} !== {1'b0, 32'h3000, 32'h0, 5'h0A, 1'b1}) begin
      tests_failed++; $display("FAIL drain_hold got %b %h %h %h %b exp 0 3000 0 0a 1", out_valid, out_pc, out_instr, out_exc, out_bd);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3] = '{32'h3000, 32'h3004, 32'h3008};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = pcs[i]; in_instr = $urandom; in_exc = 5'(i + 3); in_bd = i[0];
      step();
      tests_run++;
      if ({out_valid, in_ready, out_pc, out_exc, out_bd} !== {1'b1, 1'b1, pcs[i], 5'(i + 3), i[0]}) begin
        tests_failed++; $display("FAIL stream_%0d got v%b r%b %h %h %b exp v1 r1 %h %h %b", i, out_valid, in_ready, out_pc, out_exc, out_bd, pcs[i], 5'(i + 3), i[0]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h1111;
    step();
    in_pc = 32'h3004; in_instr = 32'h2222;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h3000}) begin
      tests_failed++; $display("FAIL bp_full got v%b r%b %h exp v1 r0 3000", out_valid, in_ready, out_pc);
    end
    step();
    tests_run++;
    if (stall_cnt !== 16'd2) begin tests_failed++; $display("FAIL bp_stall got %0d exp 2", stall_cnt); end
    out_ready = 1'b1;
    step();
    tests_run++;
    if ({out_valid, in_ready, out_pc, out_instr} !== {1'b1, 1'b1, 32'h3004, 32'h2222}) begin
      tests_failed++; $display("FAIL bp_second got v%b r%b %h %h exp v1 r1 3004 2222", out_valid, in_ready, out_pc, out_instr);
    end
    step();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd2}) begin
      tests_failed++; $display("FAIL bp_drained got v%b %0d exp v0 2", out_valid, stall_cnt);
    end
  endtask

  task automatic test_req();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3100; in_instr = 32'hAAAA;
    step();
    in_pc = 32'h3104;
    step();
    req = 1'b1; in_pc = 32'h5000;
    step();
    req = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, out_pc, out_instr, out_exc, out_bd} !== {1'b0, 1'b1, 32'h4180, 32'h0, 5'h0, 1'b0}) begin
      tests_failed++; $display("FAIL req_full got v%b r%b %h %h %h %b exp v0 r1 4180 0 0 0", out_valid, in_ready, out_pc, out_instr, out_exc, out_bd);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL req_entries_gone got %b exp 0", out_valid); end
  endtask

  task automatic test_req_flush();
    req = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5000; out_ready = 1'b1;
    step();
    req = 1'b0; flush = 1'b0;
    tests_run++;
    if ({out_valid, out_pc} !== {1'b0, 32'h4180}) begin
      tests_failed++; $display("FAIL req_beats_flush got v%b %h exp v0 4180", out_valid, out_pc);
    end
    in_pc = 32'h3000; in_instr = 32'h7777; out_ready = 1'b0;
    step();
    flush = 1'b1; in_pc = 32'h6000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, out_pc, out_instr} !== {1'b0, 1'b1, 32'h3000, 32'h0}) begin
      tests_failed++; $display("FAIL flush_one got v%b r%b %h %h exp v0 r1 3000 0", out_valid, in_ready, out_pc, out_instr);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_input_dropped got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_n = $urandom_range(0, 99) != 0;
      req = $urandom_range(0, 39) == 0;
      flush = $urandom_range(0, 29) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_pc = $urandom; in_instr = $urandom; in_exc = 5'($urandom_range(0, 31)); in_bd = 1'($urandom_range(0, 1));
      step();
      tests_run++;
      if ({out_valid, in_ready, out_pc, out_instr, out_exc, out_bd, stall_cnt} !==
          {mq.size() != 0, m_rdy, m_out.pc, m_out.instr, m_out.exc, m_out.bd, m_stall}) begin
        tests_failed++;
        $display("FAIL random_%0d got v%b r%b %h %h %h %b %h exp v%b r%b %h %h %h %b %h", i,
                 out_valid, in_ready, out_pc, out_instr, out_exc, out_bd, stall_cnt,
                 mq.size() != 0, m_rdy, m_out.pc, m_out.instr, m_out.exc, m_out.bd, m_stall);
      end
    end
    reset_n = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stall_sat();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3000;
    step();
    in_valid = 1'b0;
    repeat (70000) step();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b1, 16'hFFFF}) begin
      tests_failed++; $display("FAIL stall_saturate got v%b %h exp v1 ffff", out_valid, stall_cnt);
    end
    tests_run++;
    if (stall_cnt !== m_stall) begin tests_failed++; $display("FAIL stall_model got %h exp %h", stall_cnt, m_stall); end
    reset_n = 1'b0;
    step();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'h0}) begin
      tests_failed++; $display("FAIL stall_reset got v%b %h exp v0 0", out_valid, stall_cnt);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_req();
    test_req_flush();
    test_random();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
